// File: rtl/rsa_core_obuf.sv
// Result buffer behind the RSA core: captures {err, data} on each done rising edge into a
// first-word-fall-through FIFO and presents it on a valid/ready stream.
module rsa_core_obuf #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  obuf_clk,
    input  logic                  obuf_rst,
    input  logic                  obuf_done,
    input  logic                  obuf_err,
    input  logic [DATA_WIDTH-1:0] obuf_din,
    input  logic                  obuf_clr,
    input  logic                  obuf_ready,
    output logic                  obuf_valid,
    output logic [DATA_WIDTH-1:0] obuf_dout,
    output logic                  obuf_derr,
    output logic [DEPTH_LOG2:0]   obuf_count,
    output logic                  obuf_full,
    output logic                  obuf_ovf
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_WIDTH:0]   mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  done_q;
    logic                  ovf_q, ovf_d;
    logic                  push, pop, push_ok, valid, full;

    assign valid   = (count_q != '0);
    assign full    = (count_q == DEPTH_CNT);
    assign push    = obuf_done & ~done_q;
    assign pop     = obuf_ready & valid;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = push & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (obuf_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push_ok && pop) begin
                count_d = count_q - 1'b1;
            end
            if (push && !push_ok) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge obuf_clk or posedge obuf_rst) begin
        if (obuf_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            done_q   <= obuf_done;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge obuf_clk or posedge obuf_rst) begin
        if (obuf_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok && !obuf_clr) begin
            mem_q[wr_ptr_q] <= {obuf_err, obuf_din};
        end
    end

    // Head is masked while empty so stale slots never leak onto the stream.
    assign obuf_valid = valid;
    assign obuf_full  = full;
    assign obuf_count = count_q;
    assign obuf_ovf   = ovf_q;
    assign obuf_dout  = valid ? mem_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
    assign obuf_derr  = valid ? mem_q[rd_ptr_q][DATA_WIDTH] : 1'b0;

endmodule

// File: tb/tb_rsa_core_obuf.sv
// Directed bench for rsa_core_obuf: edge capture, FWFT latency, overflow, wrap, clear, async reset.
module tb_rsa_core_obuf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done = 1'b0;
    logic       err = 1'b0;
    logic [7:0] din = 8'h00;
    logic       clr = 1'b0;
    logic       ready = 1'b0;
    logic       valid;
    logic [7:0] dout;
    logic       derr;
    logic [2:0] count;
    logic       full;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    rsa_core_obuf #(
        .DATA_WIDTH(8),
        .DEPTH_LOG2(2)
    ) dut (
        .obuf_clk  (clk),
        .obuf_rst  (rst),
        .obuf_done (done),
        .obuf_err  (err),
        .obuf_din  (din),
        .obuf_clr  (clr),
        .obuf_ready(ready),
        .obuf_valid(valid),
        .obuf_dout (dout),
        .obuf_derr (derr),
        .obuf_count(count),
        .obuf_full (full),
        .obuf_ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] d, input logic e);
        din  = d;
        err  = e;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] exp_q [4];

        // Reset state
        #2;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full",  32'(full),  32'd0);
        check("rst_ovf",   32'(ovf),   32'd0);
        check("rst_dout",  32'(dout),  32'd0);
        check("rst_derr",  32'(derr),  32'd0);
        tick();
        rst = 1'b0;

        // Level held three cycles gives one push, visible after the first edge
        din  = 8'h5A;
        err  = 1'b0;
        done = 1'b1;
        tick();
        check("t1_valid", 32'(valid), 32'd1);
        check("t1_dout",  32'(dout),  32'h5A);
        check("t1_derr",  32'(derr),  32'd0);
        check("t1_count", 32'(count), 32'd1);
        tick();
        tick();
        done = 1'b0;
        tick();
        check("t1_single", 32'(count), 32'd1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t1_pop_valid", 32'(valid), 32'd0);
        check("t1_pop_count", 32'(count), 32'd0);

        // Five captures into a depth-4 FIFO: fifth dropped, overflow sticks
        for (int i = 1; i <= 5; i++) begin
            pulse(8'(i), (i == 3));
        end
        check("t2_count", 32'(count), 32'd4);
        check("t2_full",  32'(full),  32'd1);
        check("t2_ovf",   32'(ovf),   32'd1);
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t2_drain%0d", i), 32'(dout), 32'(i));
            check($sformatf("t2_derr%0d", i),  32'(derr), 32'(i == 3));
            tick();
        end
        ready = 1'b0;
        check("t2_empty", 32'(valid), 32'd0);
        check("t2_ovf_sticky", 32'(ovf), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t2_clr_ovf", 32'(ovf), 32'd0);

        // Full FIFO, push coincident with pop: accepted, no overflow, write wraps
        for (int i = 1; i <= 4; i++) begin
            pulse(8'(i), 1'b0);
        end
        check("t3_full", 32'(full), 32'd1);
        din   = 8'h77;
        done  = 1'b1;
        ready = 1'b1;
        tick();
        done  = 1'b0;
        ready = 1'b0;
        check("t3_count", 32'(count), 32'd4);
        check("t3_ovf",   32'(ovf),   32'd0);
        check("t3_head",  32'(dout),  32'h02);
        tick();
        check("t3_hold",  32'(dout),  32'h02);
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h77};
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_drain%0d", i), 32'(dout), 32'(exp_q[i]));
            tick();
        end
        ready = 1'b0;
        check("t3_empty", 32'(valid), 32'd0);

        // Clear with coincident done edge and ready: everything discarded
        for (int i = 0; i < 5; i++) begin
            pulse(8'h10 + 8'(i), 1'b0);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t4_count3", 32'(count), 32'd3);
        check("t4_ovf1",   32'(ovf),   32'd1);
        clr   = 1'b1;
        din   = 8'h99;
        done  = 1'b1;
        ready = 1'b1;
        tick();
        clr   = 1'b0;
        ready = 1'b0;
        check("t4_count", 32'(count), 32'd0);
        check("t4_valid", 32'(valid), 32'd0);
        check("t4_ovf",   32'(ovf),   32'd0);
        tick();
        check("t4_no_recapture", 32'(count), 32'd0);
        done = 1'b0;
        tick();

        // Async reset mid-cycle, then done held high across release
        pulse(8'h21, 1'b0);
        pulse(8'h22, 1'b1);
        check("t5_count2", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(valid), 32'd0);
        check("t5_rst_count", 32'(count), 32'd0);
        check("t5_rst_dout",  32'(dout),  32'd0);
        din  = 8'h33;
        err  = 1'b1;
        done = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        check("t5_push_count", 32'(count), 32'd1);
        check("t5_push_dout",  32'(dout),  32'h33);
        check("t5_push_derr",  32'(derr),  32'd1);
        tick();
        check("t5_held_count", 32'(count), 32'd1);
        done = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
